// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the FIFO read side, the stream adapter and the stream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns the read side of a synchronous FIFO (one cycle read latency) into a
// valid/ready stream. A two-entry skid buffer plus an in-flight flag lets the
// adapter keep reading while the sink is accepting, giving one word per cycle.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    logic [1:0]            occ;
    logic                  infl;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            pending;

    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = head;
    assign pop            = bus.m_valid && bus.m_ready;
    assign pending        = {1'b0, occ} + {2'b00, infl};
    assign rd_en          = rst && !bus.fifo_empty && !flush && ((pending < 3'd2) || pop);
    assign bus.fifo_rd_en = rd_en;

    // Buffer update: pop the head on a handshake, append the word arriving from the FIFO behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= 2'd0;
            infl <= 1'b0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ  <= 2'd0;
            infl <= 1'b0;
        end else begin
            infl <= rd_en;
            case ({pop, infl})
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= bus.fifo_r_data;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_r_data;
                    end
                end
                2'b10: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        head <= bus.fifo_r_data;
                    end else begin
                        tail <= bus.fifo_r_data;
                    end
                    occ <= occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake counter; counts pops even in a flush cycle and wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a queue-based FIFO and an abstract buffer model
// (queue of words plus one pending-read flag) predict every output each cycle.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] xfer_cnt;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] outBuf[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] expWords[$];
    int            hsCycles[$];
    bit            modelInfl;
    int            modelCnt;
    bit            prevRdEn;
    int            underflowCnt;
    int            vecCount;
    int            missCount;
    int            cycleNum;
    int            rdPulses;
    int            firstRd;
    int            firstValid;
    bit            sawWrap;
    logic [CW-1:0] lastCnt;
    logic [DW-1:0] wA, wB, wC, wD;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic clearStats();
        cycleNum   = 0;
        rdPulses   = 0;
        firstRd    = -1;
        firstValid = -1;
        delivered.delete();
        hsCycles.delete();
    endtask

    task automatic applyStimulus(input bit rdy, input bit fl, input bit rstVal);
        bit            expRd;
        bit            expPop;
        bit            empty;
        logic [DW-1:0] capData;
        @(negedge clk);
        rst = rstVal;
        if (prevRdEn) begin
            if (fifoQ.size() == 0) underflowCnt++;
            else bus.fifo_r_data = fifoQ.pop_front();
        end
        bus.fifo_empty = (fifoQ.size() == 0);
        bus.m_ready    = rdy;
        flush          = fl;
        if (!rstVal) begin
            outBuf.delete();
            modelInfl = 1'b0;
            modelCnt  = 0;
        end
        #1;
        cycleNum++;
        empty  = (fifoQ.size() == 0);
        expPop = rstVal && (outBuf.size() != 0) && rdy;
        expRd  = rstVal && !empty && !fl && (((outBuf.size() + int'(modelInfl)) < 2) || expPop);
        checkOutput("rd_en", bus.fifo_rd_en, expRd);
        checkOutput("m_valid", bus.m_valid, outBuf.size() != 0);
        if (outBuf.size() != 0) checkOutput("m_data", bus.m_data, outBuf[0]);
        else if (!rstVal) checkOutput("m_data_rst", bus.m_data, 0);
        checkOutput("xfer_cnt", xfer_cnt, modelCnt % (1 << CW));
        if (bus.fifo_rd_en) begin
            rdPulses++;
            if (firstRd < 0) firstRd = cycleNum;
        end
        if (bus.m_valid && firstValid < 0) firstValid = cycleNum;
        if (bus.m_valid && bus.m_ready) begin
            delivered.push_back(bus.m_data);
            hsCycles.push_back(cycleNum);
        end
        if (lastCnt == 4'd15 && xfer_cnt == 4'd0) sawWrap = 1'b1;
        lastCnt  = xfer_cnt;
        prevRdEn = bus.fifo_rd_en;
        capData  = bus.fifo_r_data;
        @(posedge clk);
        if (rstVal) begin
            if (expPop) begin
                void'(outBuf.pop_front());
                modelCnt++;
            end
            if (fl) begin
                outBuf.delete();
                modelInfl = 1'b0;
            end else begin
                if (modelInfl) outBuf.push_back(capData);
                modelInfl = expRd;
            end
        end
    endtask

    task automatic checkDelivered(input string tag);
        checkOutput({tag, "_count"}, delivered.size(), expWords.size());
        for (int i = 0; i < expWords.size() && i < delivered.size(); i++)
            checkOutput({tag, "_word"}, delivered[i], expWords[i]);
    endtask

    initial begin
        vecCount     = 0;
        missCount    = 0;
        underflowCnt = 0;
        prevRdEn     = 1'b0;
        modelInfl    = 1'b0;
        modelCnt     = 0;
        lastCnt      = '0;
        sawWrap      = 1'b0;
        rst          = 1'b0;
        flush        = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_r_data = '0;
        bus.m_ready     = 1'b0;
        clearStats();

        $display("[TB] reset with FIFO preloaded, then basic streaming");
        fifoQ = {8'h11, 8'h22, 8'h33};
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        clearStats();
        repeat (7) applyStimulus(1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("first_rd_cycle", firstRd, 1);
        checkOutput("latency", firstValid - firstRd, 2);
        expWords = {8'h11, 8'h22, 8'h33};
        checkDelivered("basic");
        for (int i = 1; i < hsCycles.size(); i++)
            checkOutput("basic_gap", hsCycles[i] - hsCycles[0], i);
        checkOutput("basic_cnt", xfer_cnt, 3);

        $display("[TB] back-pressure with 5 words queued");
        expWords.delete();
        for (int i = 0; i < 5; i++) begin
            expWords.push_back(DW'($urandom));
            fifoQ.push_back(expWords[i]);
        end
        clearStats();
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("bp_rd_pulses", rdPulses, 2);
        checkOutput("bp_hold_data", bus.m_data, expWords[0]);
        checkOutput("bp_hold_valid", bus.m_valid, 1);
        clearStats();
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b1);
        checkDelivered("bp");
        for (int i = 0; i < hsCycles.size(); i++)
            checkOutput("bp_gap", hsCycles[i], i + 1);

        $display("[TB] empty FIFO with toggling ready");
        clearStats();
        for (int i = 0; i < 10; i++) applyStimulus(i[0], 1'b0, 1'b1);
        checkOutput("empty_rd_pulses", rdPulses, 0);
        checkOutput("empty_underflow", underflowCnt, 0);
        checkOutput("empty_valid", firstValid, -1);

        $display("[TB] flush with one word buffered and one in flight");
        wA = DW'($urandom); wB = DW'($urandom); wC = DW'($urandom); wD = DW'($urandom);
        fifoQ.push_back(wA);
        clearStats();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        fifoQ.push_back(wB);
        fifoQ.push_back(wC);
        fifoQ.push_back(wD);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("flush_pre_rd", rdPulses, 2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("flush_valid", bus.m_valid, 0);
        clearStats();
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
        expWords = {wC, wD};
        checkDelivered("flush");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) fifoQ.push_back(DW'($urandom));
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b1);
        end
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b1);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 8; i++) fifoQ.push_back(DW'($urandom));
        clearStats();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_valid", bus.m_valid, 0);
        checkOutput("async_rd_en", bus.fifo_rd_en, 0);
        checkOutput("async_cnt", xfer_cnt, 0);
        outBuf.delete();
        modelInfl = 1'b0;
        modelCnt  = 0;
        lastCnt   = '0;
        expWords  = fifoQ;
        if (prevRdEn && expWords.size() != 0) void'(expWords.pop_front());
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        clearStats();
        repeat (expWords.size() + 5) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("async_first_rd", firstRd, 1);
        checkDelivered("async");

        $display("[TB] counter wrap over 17 handshakes");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        fifoQ.delete();
        expWords.delete();
        for (int i = 0; i < 17; i++) begin
            expWords.push_back(DW'($urandom));
            fifoQ.push_back(expWords[i]);
        end
        clearStats();
        sawWrap = 1'b0;
        repeat (22) applyStimulus(1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("wrap_cnt", xfer_cnt, 1);
        checkOutput("wrap_seen", sawWrap, 1);
        checkDelivered("wrap");
        checkOutput("underflow_total", underflowCnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
